instr_encoder: RTL
==================

# instr_encoder

Streaming RISC-V RV32I instruction encoder: the inverse of the core's immediate extender. It accepts decoded instruction fields plus a signed 32-bit immediate and scatters the immediate back into the I/S/B/J/U bit layouts. It emits the finished 32-bit word together with a sequential program-memory write address. It sits between the bench/boot loader and instruction memory, and generates and round-trip-checks programs for the single-cycle core.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: first write address after reset or `restart`.
- MEM_WORDS, 64: instruction memory depth in words; the address wraps modulo MEM_WORDS*4.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- restart  in  1  synchronous; reloads the address counter to BASE_ADDR and flushes both pipeline stages.
- in_valid  in  1  input field bundle valid.
- in_ready  out  1  encoder can accept the bundle this cycle.
- in_fmt  in  3  format: 0=I, 1=S, 2=B, 3=J (same codes as imm_src), 4=U, 5=R, 6/7 reserved.
- in_opcode  in  7  major opcode.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field, used by R only.
- in_imm  in  32  signed immediate (byte offset for B/J; full upper value for U).
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  32  memory address for out_instr.
- out_err  out  1  immediate out of range, misaligned, or reserved format.

## Operation
- Two-stage pipeline with valid/ready on both sides. A transfer occurs when valid and ready are both high on a rising clk edge.
- Stage 1 (S1) registers the accepted fields, then computes the range/alignment check and the packed word.
- Stage 2 (S2) holds the output registers: out_instr, out_err, out_addr.
- Immediate legality:
  - I/S: -2048..2047.
  - B: -4096..4094, must be even.
  - J: -1048576..1048574, must be even.
  - U: in_imm[11:0] must be 0.
  - R: imm ignored.
  - Reserved format: always an error.
- Packing (opcode always in [6:0]):
  - I: imm[11:0] goes to [31:20].
  - S: imm[11:5] to [31:25], imm[4:0] to [11:7].
  - B: imm[12] to [31], imm[10:5] to [30:25], imm[4:1] to [11:8], imm[11] to [7].
  - J: imm[20] to [31], imm[10:1] to [30:21], imm[11] to [20], imm[19:12] to [19:12].
  - U: imm[31:12] to [31:12].
  - R: funct7 to [31:25].
  - rs2 only for S/B/R; rs1 and funct3 only for I/S/B/R; rd only for I/J/U/R. Unused fields are 0.
- On error, the word is still emitted, packed from the truncated immediate, with out_err=1.
- Address counter:
  - Increments by 4 on each output transfer, error words included.
  - Wraps from BASE_ADDR+MEM_WORDS*4-4 back to BASE_ADDR.
  - out_addr shows the counter value for the word currently held in S2.

## Timing
- Reset values: out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, both stage valids 0.
- in_ready is high out of reset. It is combinational: `!s1_valid || s1_moves`, where `s1_moves = !s2_valid || out_ready`.
- Latency: a bundle accepted at edge N gives out_valid=1 after edge N+1, with no stall.
- Throughput: one word per cycle when out_ready is held high.
- Backpressure:
  - With out_ready low, S2 holds its word stable.
  - S1 accepts one more bundle, then in_ready drops.
  - No word is dropped or duplicated.
- Simultaneous output transfer and input acceptance in the same cycle is legal; the pipeline stays full.
- restart: takes priority over everything. It clears both valids and sets the address to BASE_ADDR at the next edge. in_ready is 0 during the restart cycle.
- Reset mid-stream: everything returns to reset values immediately, because the reset is asynchronous.

## Structure
- Package `instr_encoder_pkg`: the format enum (I/S/B/J/U/R plus reserved), opcode constants (OP_IMM=7'h13, STORE=7'h23, BRANCH=7'h63, JAL=7'h6f, LUI=7'h37, OP=7'h33), and a field-bundle struct. The core's extender imports the same I/S/B/J codes.
- Sub-module `imm_pack` (combinational): takes the format, fields and immediate, and returns the packed word and the error bit.
- Top level holds the two stage registers, the handshake logic and the address counter.

## Test plan
- I-type: fmt=0, opcode 0x13, rd=17, rs1=0, funct3=0, imm=10 -> out_instr=0x00a00893, out_err=0, out_addr=BASE_ADDR, two cycles after acceptance.
- S and B types back-to-back:
  - S: rs1=2, rs2=5, funct3=2, imm=-4 -> 0xfe512e23.
  - B: rs1=1, rs2=2, funct3=0, imm=8 -> 0x00208463.
  - out_addr advances by 4 between the two words.
- J and U types:
  - J: rd=0, imm=0 -> 0x0000006f.
  - U: LUI, rd=1, imm=0x12345000 -> 0x123450b7.
  - U: imm=0x12345001 -> out_err=1.
- Errors:
  - B with imm=5 -> out_err=1.
  - I with imm=2048 -> out_err=1.
  - fmt=6 -> out_err=1.
  - The address still increments after each error word.
- Backpressure:
  - Hold out_ready low for 3 cycles during a 4-word burst.
  - Exactly two bundles are accepted before in_ready drops.
  - Output order and values are preserved.
- Wrap, restart and reset:
  - With MEM_WORDS=4, the 5th word has out_addr=BASE_ADDR.
  - restart while the pipeline is full -> out_valid=0 next cycle, address back to BASE_ADDR.
  - rst asserted mid-burst -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared types for the RV32I instruction encoder: format codes, opcodes and
// the decoded field bundle carried through the first pipeline stage.
package instr_encoder_pkg;

  // I/S/B/J codes match the core's imm_src encoding.
  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_J    = 3'd3,
    FMT_U    = 3'd4,
    FMT_R    = 3'd5,
    FMT_RSV6 = 3'd6,
    FMT_RSV7 = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_OP     = 7'h33;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational packer: scatters the immediate into the RV32I layout for the
// given format and flags out-of-range, misaligned or reserved encodings.
module imm_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        err
);

  logic signed [31:0] simm;
  assign simm = imm;

  always_comb begin
    // Reserved formats emit the bare opcode so the word is still deterministic.
    word = {25'd0, opcode};
    err  = 1'b0;
    case (fmt_e'(fmt))
      FMT_I: begin
        word = {imm[11:0], rs1, funct3, rd, opcode};
        err  = (simm < -2048) || (simm > 2047);
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = (simm < -2048) || (simm > 2047);
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = (simm < -4096) || (simm > 4094) || imm[0];
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = (simm < -1048576) || (simm > 1048574) || imm[0];
      end
      FMT_U: begin
        word = {imm[31:12], rd, opcode};
        err  = (imm[11:0] != 12'd0);
      end
      FMT_R: begin
        word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage streaming RV32I encoder: S1 captures fields, S2 holds the packed
// word with its program-memory address. Valid/ready on both sides.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Producers must hold their bundle stable until it transfers.

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(MEM_WORDS * 4) - 32'd4;

  logic        s1_valid_q, s1_valid_d;
  fields_t     s1_q, s1_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic        s1_moves, out_fire;
  logic [31:0] pack_word;
  logic        pack_err;

  imm_pack u_pack (
    .fmt    (s1_q.fmt),
    .opcode (s1_q.opcode),
    .rd     (s1_q.rd),
    .rs1    (s1_q.rs1),
    .rs2    (s1_q.rs2),
    .funct3 (s1_q.funct3),
    .funct7 (s1_q.funct7),
    .imm    (s1_q.imm),
    .word   (pack_word),
    .err    (pack_err)
  );

  always_comb begin
    s1_moves   = !s2_valid_q || out_ready;
    in_ready   = !restart && (!s1_valid_q || s1_moves);
    out_fire   = s2_valid_q && out_ready;
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    instr_d    = instr_q;
    err_d      = err_q;
    addr_d     = addr_q;
    if (restart) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      addr_d     = BASE_ADDR;
    end else begin
      if (in_ready) begin
        s1_valid_d = in_valid;
        if (in_valid) begin
          s1_d = '{fmt: fmt_e'(in_fmt), opcode: in_opcode, rd: in_rd, rs1: in_rs1,
                   rs2: in_rs2, funct3: in_funct3, funct7: in_funct7, imm: in_imm};
        end
      end
      if (s1_moves) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          instr_d = pack_word;
          err_d   = pack_err;
        end
      end
      // The counter names the word in S2, so it advances as that word leaves.
      if (out_fire) begin
        addr_d = (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      instr_q    <= '0;
      err_q      <= 1'b0;
      addr_q     <= BASE_ADDR;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      instr_q    <= instr_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign out_addr  = addr_q;

endmodule
